// File: rtl/imem_loader.sv
// Nibble-serial program loader: hunts for a header nibble, assembles 16-bit
// words into the instruction memory, and verifies a trailing XOR checksum.
module imem_loader #(
  parameter int          WORDS      = 8,
  parameter int          ADDR_WIDTH = 3,
  parameter logic [3:0]  HEADER     = 4'hA
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load_req,
  input  logic                  nib_valid,
  input  logic [3:0]            nib_data,
  output logic                  nib_ready,
  output logic                  wr,
  output logic [ADDR_WIDTH-1:0] w_addr,
  output logic [15:0]           w_data,
  output logic                  done,
  output logic                  err,
  output logic                  cpu_en
);

  typedef enum logic [2:0] {
    S_HUNT,
    S_DATA,
    S_CSUM,
    S_DONE,
    S_ERROR
  } state_t;

  localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(WORDS - 1);

  state_t                state_q, state_d;
  logic [1:0]            cnt_q, cnt_d;
  logic [11:0]           hold_q, hold_d;
  logic [ADDR_WIDTH-1:0] idx_q, idx_d;
  logic [3:0]            xor_q, xor_d;
  logic                  wr_q, wr_d;
  logic [ADDR_WIDTH-1:0] waddr_q, waddr_d;
  logic [15:0]           wdata_q, wdata_d;
  logic                  accept;

  assign nib_ready = (state_q == S_HUNT) || (state_q == S_DATA) || (state_q == S_CSUM);
  assign accept    = nib_valid && nib_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_HUNT;
      cnt_q   <= '0;
      hold_q  <= '0;
      idx_q   <= '0;
      xor_q   <= '0;
      wr_q    <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hold_q  <= hold_d;
      idx_q   <= idx_d;
      xor_q   <= xor_d;
      wr_q    <= wr_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hold_d  = hold_q;
    idx_d   = idx_q;
    xor_d   = xor_q;
    wr_d    = 1'b0;
    waddr_d = waddr_q;
    wdata_d = wdata_q;

    // A restart wins over any nibble offered in the same cycle.
    if (load_req) begin
      state_d = S_HUNT;
    end else if (accept) begin
      case (state_q)
        S_HUNT: begin
          if (nib_data == HEADER) begin
            state_d = S_DATA;
            cnt_d   = '0;
            idx_d   = '0;
            xor_d   = '0;
          end
        end
        S_DATA: begin
          xor_d = xor_q ^ nib_data;
          if (cnt_q == 2'd3) begin
            wr_d    = 1'b1;
            waddr_d = idx_q;
            wdata_d = {nib_data, hold_q};
            idx_d   = idx_q + 1'b1;
            cnt_d   = '0;
            if (idx_q == LAST_IDX) state_d = S_CSUM;
          end else begin
            // Least-significant nibble arrives first, so shift in from the top.
            hold_d = {nib_data, hold_q[11:4]};
            cnt_d  = cnt_q + 2'd1;
          end
        end
        S_CSUM: begin
          state_d = (nib_data == xor_q) ? S_DONE : S_ERROR;
        end
        default: ;
      endcase
    end
  end

  assign wr     = wr_q;
  assign w_addr = waddr_q;
  assign w_data = wdata_q;
  assign done   = (state_q == S_DONE);
  assign err    = (state_q == S_ERROR);
  assign cpu_en = done;

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: directed scenarios plus randomized images
// compared against a word-level reference model of the frame format.
module tb_imem_loader;

  localparam logic [3:0] HDR = 4'hA;

  logic        clk = 1'b0;
  logic        rst;
  logic        load_req;
  logic        nib_valid;
  logic [3:0]  nib_data;
  logic        nib_ready;
  logic        wr;
  logic [2:0]  w_addr;
  logic [15:0] w_data;
  logic        done;
  logic        err;
  logic        cpu_en;

  int checks = 0;
  int errors = 0;
  logic [15:0] img [8];

  imem_loader #(.WORDS(8), .ADDR_WIDTH(3), .HEADER(4'hA)) dut (
    .clk(clk), .rst(rst), .load_req(load_req), .nib_valid(nib_valid),
    .nib_data(nib_data), .nib_ready(nib_ready), .wr(wr), .w_addr(w_addr),
    .w_data(w_data), .done(done), .err(err), .cpu_en(cpu_en)
  );

  initial forever #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock: drive inputs, let the edge happen, sample 1ns later.
  task automatic cyc(input logic v, input logic [3:0] d);
    nib_valid = v;
    nib_data  = d;
    @(posedge clk);
    #1;
  endtask

  // Reference checksum: XOR of every nibble of every image word.
  function automatic logic [3:0] img_xor();
    logic [3:0] x = 4'h0;
    for (int i = 0; i < 8; i++)
      x = x ^ img[i][3:0] ^ img[i][7:4] ^ img[i][11:8] ^ img[i][15:12];
    return x;
  endfunction

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_ready"}, nib_ready, 1);
    chk({tag, "_wr"}, wr, 0);
    chk({tag, "_addr"}, w_addr, 0);
    chk({tag, "_data"}, w_data, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_err"}, err, 0);
    chk({tag, "_cpu_en"}, cpu_en, 0);
  endtask

  task automatic stall(input int mode);
    int k;
    k = (mode == 2) ? 1 : (mode == 1) ? int'($urandom_range(0, 2)) : 0;
    for (int s = 0; s < k; s++) begin
      cyc(1'b0, 4'($urandom));
      chk("stall_wr", wr, 0);
    end
  endtask

  // Send a full frame for img[] with the given checksum nibble.
  // stall_mode: 0 none, 1 random idle cycles, 2 one idle before each nibble.
  task automatic run_frame(input logic [3:0] csum, input int stall_mode, input bit send_csum);
    bit ok;
    ok = (csum == img_xor());
    cyc(1'b1, HDR);
    chk("hdr_wr", wr, 0);
    for (int w = 0; w < 8; w++) begin
      for (int n = 0; n < 4; n++) begin
        stall(stall_mode);
        cyc(1'b1, img[w][4*n +: 4]);
        if (n == 3) begin
          chk("word_wr", wr, 1);
          chk("word_addr", w_addr, w);
          chk("word_data", w_data, img[w]);
        end else begin
          chk("nib_wr", wr, 0);
        end
      end
    end
    chk("pre_done", done, 0);
    chk("pre_ready", nib_ready, 1);
    if (send_csum) begin
      stall(stall_mode);
      cyc(1'b1, csum);
      chk("end_done", done, ok);
      chk("end_cpu_en", cpu_en, ok);
      chk("end_err", err, !ok);
      chk("end_ready", nib_ready, 0);
      chk("end_wr", wr, 0);
    end
  endtask

  // Restart with a header offered in the same cycle; that header must be dropped.
  task automatic restart();
    load_req = 1'b1;
    cyc(1'b1, HDR);
    load_req = 1'b0;
    chk("rq_done", done, 0);
    chk("rq_err", err, 0);
    chk("rq_cpu_en", cpu_en, 0);
    chk("rq_wr", wr, 0);
    chk("rq_ready", nib_ready, 1);
  endtask

  initial begin
    rst = 1'b0; load_req = 1'b0; nib_valid = 1'b0; nib_data = 4'h0;
    repeat (2) @(posedge clk);
    #1;
    chk_reset_vals("reset");
    rst = 1'b1;
    cyc(1'b0, 4'h0);

    // Clean load of 0x1234 words, checksum 0.
    for (int i = 0; i < 8; i++) img[i] = 16'h1234;
    run_frame(img_xor(), 0, 1'b1);
    cyc(1'b1, HDR);
    chk("done_sticky", done, 1);
    chk("done_noacc_wr", wr, 0);
    chk("done_ready", nib_ready, 0);
    restart();

    // Bad checksum 5 on the same image.
    run_frame(img_xor() ^ 4'h5, 0, 1'b1);
    cyc(1'b1, 4'h3);
    chk("err_sticky", err, 1);
    chk("err_cpu_en", cpu_en, 0);
    chk("err_noacc_wr", wr, 0);
    restart();

    // Header hunt: junk nibbles before the header.
    cyc(1'b1, 4'h3); chk("hunt_wr3", wr, 0);
    cyc(1'b1, 4'hF); chk("hunt_wrF", wr, 0);
    cyc(1'b1, 4'h0); chk("hunt_wr0", wr, 0);
    chk("hunt_ready", nib_ready, 1);
    run_frame(img_xor(), 0, 1'b1);
    restart();

    // Alternating valid / idle.
    run_frame(img_xor(), 2, 1'b1);
    restart();

    // Restart after 6 data nibbles; partial word 1 must never be written.
    cyc(1'b1, HDR);
    for (int i = 0; i < 6; i++) begin
      cyc(1'b1, img[i/4][4*(i%4) +: 4]);
      chk("ab_wr", wr, (i == 3) ? 1 : 0);
    end
    load_req = 1'b1;
    cyc(1'b1, img[1][11:8]);
    load_req = 1'b0;
    chk("ab_rq_wr", wr, 0);
    for (int i = 0; i < 3; i++) begin
      cyc(1'b1, img[1][15:12]);
      chk("ab_idle_wr", wr, 0);
    end
    for (int i = 0; i < 8; i++) img[i] = 16'(i + 1);
    chk("ab_model_csum", img_xor(), 4'h8);
    run_frame(img_xor(), 0, 1'b1);
    restart();

    // Randomized images, random stalls, random checksum corruption.
    for (int t = 0; t < 6; t++) begin
      logic [3:0] c;
      for (int i = 0; i < 8; i++) img[i] = 16'($urandom);
      c = img_xor();
      if ($urandom_range(0, 1) == 1) c = c ^ 4'(1 + $urandom_range(0, 14));
      run_frame(c, 1, 1'b1);
      restart();
    end

    // Asynchronous reset for half a cycle while waiting for the checksum.
    for (int i = 0; i < 8; i++) img[i] = 16'($urandom) | 16'h0001;
    run_frame(4'h0, 0, 1'b0);
    rst = 1'b0;
    #1;
    chk_reset_vals("arst");
    #3;
    rst = 1'b1;
    cyc(1'b0, 4'h0);
    chk("arst_after_wr", wr, 0);
    chk("arst_after_done", done, 0);
    run_frame(img_xor(), 0, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
